// File: rtl/mips_reg_dump.sv
// mips_reg_dump: debug read-out engine for the PIPELINE_MIPS32 core.
// Once the core halts, this walks the register file through its synchronous
// read port and streams each register out as an indexed word on a
// valid/ready channel.
// Optional build macro MIPS_REG_DUMP_CHECKSUM_EN appends one extra beat that
// carries the XOR of all dumped words; that beat is then the one marked last.

module mips_reg_dump #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIRST_REG  = 0,
  parameter int DUMP_COUNT = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halted,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  // The counter is one bit wider than the address.  The index just past the
  // last register (used for the checksum beat) can then never wrap, even when
  // the dump runs to the top of the register file.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(FIRST_REG);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FIRST_REG + DUMP_COUNT - 1);
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CSUM_IDX  = CNT_W'(FIRST_REG + DUMP_COUNT);
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    READ,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              start_accept;
  logic              beat_accept;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] xor_acc;
`endif

  assign count_inc    = count + CNT_W'(1);
  assign start_accept = start && ((state == IDLE) || (state == DONE));
  assign beat_accept  = (state == SEND) && dout_ready;

  assign rf_re      = (state == READ);
  assign dout_valid = (state == SEND);
  assign busy       = (state == WAIT_HALT) || (state == READ) ||
                      (state == CAPTURE) || (state == SEND);
  assign done       = (state == DONE);

  // State register; reset abandons any dump in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.  halted only matters while waiting for it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = WAIT_HALT;
      WAIT_HALT:  if (halted) state_next = READ;
      READ:       state_next = CAPTURE;
      CAPTURE:    state_next = SEND;
      SEND: begin
        if (dout_ready) begin
          if (dout_last) begin
            state_next = DONE;
          end else begin
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
            // After the final register the checksum needs no RF read.
            state_next = (count == LAST_IDX) ? CAPTURE : READ;
`else
            state_next = READ;
`endif
          end
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  // Register index counter; it restarts on every accepted start and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FIRST_IDX;
    end else if (start_accept) begin
      count <= FIRST_IDX;
    end else if (beat_accept && !dout_last) begin
      count <= count_inc;
    end
  end

  // Registered read address, loaded on the way into READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_raddr <= '0;
    end else if (state_next == READ) begin
      rf_raddr <= (state == SEND) ? count_inc[ADDR_W-1:0] : count[ADDR_W-1:0];
    end
  end

  // Output beat capture.  The beat is held untouched for the whole of SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_data <= '0;
      dout_idx  <= '0;
      dout_last <= 1'b0;
    end else if (state == CAPTURE) begin
      dout_idx <= count[ADDR_W-1:0];
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
      if (count == CSUM_IDX) begin
        dout_data <= xor_acc;
        dout_last <= 1'b1;
      end else begin
        dout_data <= rf_rdata;
        dout_last <= 1'b0;
      end
`else
      dout_data <= rf_rdata;
      dout_last <= (count == LAST_IDX);
`endif
    end
  end

`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  // Running XOR of every register word captured in this dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_acc <= '0;
    end else if (start_accept) begin
      xor_acc <= '0;
    end else if ((state == CAPTURE) && (count != CSUM_IDX)) begin
      xor_acc <= xor_acc ^ rf_rdata;
    end
  end
`endif

endmodule
